// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: per-instruction FSM sequencer with a variable-latency memory handshake and timeout.
// Define MC_CTRL_JAL_EN to add the JAL instruction (opcode 000011); without it that opcode decodes as illegal.
module mc_control_unit #(
    parameter int ALUCTRL_W   = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 branch,
    output logic                 branch_ne,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 imm_zext,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 reg_write,
    output logic                 illegal,
    output logic                 mem_err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4);

    // Counter only has to reach MEM_TIMEOUT-1.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP
`ifdef MC_CTRL_JAL_EN
        , S_JAL
`endif
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 mem_state;
    logic                 timeout;
    logic [ALUCTRL_W-1:0] alu_r;
    logic [ALUCTRL_W-1:0] alu_i;
    logic                 r_ok;
    logic                 i_zext;

    assign mem_state = state inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    // A ready arriving on the last permitted cycle completes the access instead of aborting it.
    assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        r_ok  = 1'b1;
        alu_r = ALU_ADD;
        case (funct)
            FN_ADD:  alu_r = ALU_ADD;
            FN_SUB:  alu_r = ALU_SUB;
            FN_AND:  alu_r = ALU_AND;
            FN_OR:   alu_r = ALU_OR;
            FN_SLT:  alu_r = ALU_SLT;
            default: r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        alu_i  = ALU_ADD;
        i_zext = 1'b0;
        case (opcode)
            OP_ANDI: begin alu_i = ALU_AND; i_zext = 1'b1; end
            OP_ORI:  begin alu_i = ALU_OR;  i_zext = 1'b1; end
            OP_SLTI: alu_i = ALU_SLT;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else if (timeout) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
        end else begin
            wait_cnt <= (mem_state && !mem_ready) ? wait_cnt + CNT_W'(1) : '0;
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:   state <= S_MEMADR;
                        OP_RTYPE: begin
                            if (r_ok) state <= S_EXEC;
                            else begin
                                state   <= S_FETCH;
                                illegal <= 1'b1;
                            end
                        end
                        OP_BEQ, OP_BNE: state <= S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= S_IEXEC;
                        OP_J:           state <= S_JUMP;
`ifdef MC_CTRL_JAL_EN
                        OP_JAL:         state <= S_JAL;
`endif
                        default: begin
                            state   <= S_FETCH;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   state <= (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXEC:     state <= S_ALUWB;
                S_IEXEC:    state <= S_IWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        imm_zext   = 1'b0;
        alu_ctrl   = ALU_ADD;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = !timeout;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD:  mem_req = !timeout;
            S_MEMWRITE: begin
                mem_req   = !timeout;
                mem_write = !timeout;
            end
            S_MEMWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = alu_r;
            end
            S_ALUWB: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                branch    = (opcode == OP_BEQ);
                branch_ne = (opcode == OP_BNE);
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = alu_i;
                imm_zext  = i_zext;
            end
            S_IWB: begin
                alu_ctrl  = alu_i;
                imm_zext  = i_zext;
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            // r31 captures the old PC+4 on the same edge the PC takes the jump target.
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
`endif
            default: ;
        endcase
    end

endmodule
